// File: rtl/uart_msg_sender.sv
// uart_msg_sender: on a one-cycle wr request, looks up a status message by
// code and streams its bytes, then the line terminator (plus LF when
// APPEND_LF=1), to a UART TX core over a send/busy handshake.
// Optional feature macro: UART_MSG_HEX_EN inserts " 0xHH" (hex of arg)
// between the message text and the terminator.
module uart_msg_sender #(
    parameter int         CODE_W    = 8,
    parameter int         BUSY_LAT  = 2,
    parameter logic [7:0] TERM      = 8'h0D,
    parameter int         APPEND_LF = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [CODE_W-1:0] msg,
    input  logic [7:0]        arg,
    input  logic              busy,
    output logic              send,
    output logic [7:0]        data,
    output logic              ready,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, STROBE, HOLD, DONE} state_t;

`ifdef UART_MSG_HEX_EN
    localparam logic [4:0] HEX_N = 5'd5;
`else
    localparam logic [4:0] HEX_N = 5'd0;
`endif
    localparam logic [4:0] LF_N = (APPEND_LF != 0) ? 5'd1 : 5'd0;

    state_t             state;
    state_t             state_nxt;
    logic [CODE_W-1:0]  msg_q;
    logic [CODE_W+7:0]  code_ext;
    logic [7:0]         code8;
    logic               known;
    logic [4:0]         msg_len;
    logic [0:13][7:0]   rom_text;
    logic [4:0]         idx;
    logic [4:0]         sel_idx;
    logic [4:0]         term_idx;
    logic [4:0]         last_idx;
    logic [7:0]         sel_byte;
    logic [3:0]         hold_cnt;
    logic               hold_end;
    logic [7:0]         data_q;
    logic               err_q;
    logic               unused_code_hi;

`ifdef UART_MSG_HEX_EN
    logic [7:0]         arg_q;
    logic [4:0]         hex_pos;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`else
    logic               unused_arg;
    assign unused_arg = ^arg;
`endif

    // Codes match on the low 8 bits; narrower codes are zero-extended.
    assign code_ext       = {8'h00, msg_q};
    assign code8          = code_ext[7:0];
    assign unused_code_hi = ^code_ext[CODE_W+7:8];

    // Message ROM: text left-aligned (byte 0 first) plus its length.
    always_comb begin
        known    = 1'b1;
        msg_len  = 5'd3;
        rom_text = '0;
        case (code8)
            8'hFF: rom_text = {"xxx", 88'h0};
            8'hFE: rom_text = {"sss", 88'h0};
            8'hFD: begin
                rom_text = {"Error crc!", 32'h0};
                msg_len  = 5'd10;
            end
            8'hFC: begin
                rom_text = "Error command!";
                msg_len  = 5'd14;
            end
            8'hFB: rom_text = {"ok!", 88'h0};
            default: begin
                known   = 1'b0;
                msg_len = 5'd0;
            end
        endcase
    end

    assign term_idx = msg_len + HEX_N;
    assign last_idx = term_idx + LF_N;
    assign sel_idx  = (state == LOOKUP) ? 5'd0 : idx + 5'd1;
    assign hold_end = (hold_cnt == 4'd1);

    // Byte at position sel_idx: text, optional hex suffix, terminator, LF.
    always_comb begin
        sel_byte = 8'h0A;
`ifdef UART_MSG_HEX_EN
        hex_pos  = sel_idx - msg_len;
`endif
        if (sel_idx < msg_len) begin
            sel_byte = rom_text[sel_idx[3:0]];
        end
`ifdef UART_MSG_HEX_EN
        else if (sel_idx < term_idx) begin
            case (hex_pos)
                5'd0:    sel_byte = 8'h20;
                5'd1:    sel_byte = 8'h30;
                5'd2:    sel_byte = 8'h78;
                5'd3:    sel_byte = hex_ascii(arg_q[7:4]);
                default: sel_byte = hex_ascii(arg_q[3:0]);
            endcase
        end
`endif
        else if (sel_idx == term_idx) begin
            sel_byte = TERM;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic for the request/lookup/byte-handshake sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr && ready) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = known ? WAIT : IDLE;
            WAIT:    if (!busy) state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    if (hold_end) state_nxt = (idx == last_idx) ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, byte index, data register, busy-ignore counter, err pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            msg_q    <= '0;
            idx      <= 5'd0;
            data_q   <= 8'h00;
            hold_cnt <= 4'd0;
            err_q    <= 1'b0;
`ifdef UART_MSG_HEX_EN
            arg_q    <= 8'h00;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr && ready) begin
                        msg_q <= msg;
                        idx   <= 5'd0;
`ifdef UART_MSG_HEX_EN
                        arg_q <= arg;
`endif
                    end
                end
                LOOKUP: begin
                    if (known) data_q <= sel_byte;
                    else       err_q  <= 1'b1;
                end
                STROBE: hold_cnt <= 4'(BUSY_LAT);
                HOLD: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_end && (idx != last_idx)) begin
                        idx    <= idx + 5'd1;
                        data_q <= sel_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign send  = (state == STROBE);
    assign done  = (state == DONE);
    assign ready = (state == IDLE) && !err_q;
    assign err   = err_q;
    assign data  = data_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Testbench for uart_msg_sender: two instances share the request/busy inputs
// (default build, and BUSY_LAT=3 with APPEND_LF=1). A scoreboard queue per
// instance holds the expected byte stream; each send strobe pops and compares.
module tb_uart_msg_sender;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       wr   = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] msg  = 8'h00;
    logic [7:0] arg  = 8'h00;

    logic       send_a, ready_a, done_a, err_a;
    logic [7:0] data_a;
    logic       send_b, ready_b, done_b, err_b;
    logic [7:0] data_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         send_cyc_a[$];
    int         sends_a = 0, sends_b = 0;
    int         dones_a = 0, dones_b = 0;
    int         errs_a  = 0, errs_b  = 0;
    int         done_cyc_a = 0, ready_rise_a = 0;
    logic       prev_send_a = 1'b0, prev_send_b = 1'b0, prev_ready_a = 1'b0;

    uart_msg_sender #(.CODE_W(8), .BUSY_LAT(2), .TERM(8'h0D), .APPEND_LF(0)) dut_a (
        .clk(clk), .rst(rst), .wr(wr), .msg(msg), .arg(arg), .busy(busy),
        .send(send_a), .data(data_a), .ready(ready_a), .done(done_a), .err(err_a)
    );

    uart_msg_sender #(.CODE_W(8), .BUSY_LAT(3), .TERM(8'h0D), .APPEND_LF(1)) dut_b (
        .clk(clk), .rst(rst), .wr(wr), .msg(msg), .arg(arg), .busy(busy),
        .send(send_b), .data(data_b), .ready(ready_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pop/compare on every strobe, record timing of pulses.
    always @(negedge clk) begin
        logic [7:0] e;
        if (send_a) begin
            checkOutput("a_no_back_to_back", prev_send_a, 0);
            checkOutput("a_sb_has_byte", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                checkOutput("a_byte", data_a, e);
            end
            send_cyc_a.push_back(cyc);
            sends_a++;
        end
        if (send_b) begin
            checkOutput("b_no_back_to_back", prev_send_b, 0);
            checkOutput("b_sb_has_byte", q_b.size() != 0, 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                checkOutput("b_byte", data_b, e);
            end
            sends_b++;
        end
        if (done_a) begin dones_a++; done_cyc_a = cyc; end
        if (done_b) dones_b++;
        if (err_a) errs_a++;
        if (err_b) errs_b++;
        if (ready_a && !prev_ready_a) ready_rise_a = cyc;
        prev_send_a  = send_a;
        prev_send_b  = send_b;
        prev_ready_a = ready_a;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pushBoth(input logic [7:0] b);
        q_a.push_back(b);
        q_b.push_back(b);
    endtask

    // Reference model of the byte stream for a given code/argument.
    task automatic pushExpected(input logic [7:0] code, input logic [7:0] a);
        string s;
`ifdef UART_MSG_HEX_EN
        string hx = "0123456789ABCDEF";
`endif
        case (code)
            8'hFF:   s = "xxx";
            8'hFE:   s = "sss";
            8'hFD:   s = "Error crc!";
            8'hFC:   s = "Error command!";
            8'hFB:   s = "ok!";
            default: s = "";
        endcase
        if (s.len() == 0) return;
        for (int i = 0; i < s.len(); i++) pushBoth(s[i]);
`ifdef UART_MSG_HEX_EN
        pushBoth(8'h20);
        pushBoth(8'h30);
        pushBoth(8'h78);
        pushBoth(hx[a[7:4]]);
        pushBoth(hx[a[3:0]]);
`else
        if (a === 8'hxx) $display("[TB] note: arg unknown");
`endif
        pushBoth(8'h0D);
        q_b.push_back(8'h0A);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!(ready_a && ready_b) && n < 400) begin
            step();
            n++;
        end
        checkOutput(tag, ready_a && ready_b, 1);
    endtask

    task automatic waitSendsA(input int target);
        int n = 0;
        while (sends_a < target && n < 200) begin
            step();
            n++;
        end
        checkOutput("reach_send_count", sends_a, target);
    endtask

    // Issues one request in the cycle labelled wcyc; inputs scrambled afterwards.
    task automatic applyStimulus(input logic [7:0] code, input logic [7:0] a, output int wcyc);
        waitIdle("idle_before_request");
        wr   = 1'b1;
        msg  = code;
        arg  = a;
        wcyc = cyc;
        pushExpected(code, a);
        step();
        wr  = 1'b0;
        msg = 8'($urandom);
        arg = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w, base, nexp, d0, db0, e0, s1, sb1;

        // Reset state
        repeat (3) step();
        checkOutput("rst_ready", ready_a, 1);
        checkOutput("rst_send", send_a, 0);
        checkOutput("rst_data", data_a, 8'h00);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_err", err_a, 0);
        rst = 1'b1;
        step();

        // 0xFB with busy low: stream, strobe spacing, done and ready timing
        base = sends_a; d0 = dones_a; db0 = dones_b;
        applyStimulus(8'hFB, 8'hA5, w);
        nexp = q_a.size();
        waitIdle("fb_finish");
        checkOutput("fb_nsend", sends_a - base, nexp);
        checkOutput("fb_first_send", send_cyc_a[base], w + 3);
        for (int i = 1; i < nexp; i++)
            checkOutput("fb_gap", send_cyc_a[base + i] - send_cyc_a[base + i - 1], 4);
        checkOutput("fb_done_after_last", done_cyc_a, send_cyc_a[base + nexp - 1] + 3);
        checkOutput("fb_ready_after_done", ready_rise_a, done_cyc_a + 1);
        checkOutput("fb_ndone_a", dones_a - d0, 1);
        checkOutput("fb_ndone_b", dones_b - db0, 1);
        checkOutput("fb_qa_empty", q_a.size(), 0);
        checkOutput("fb_qb_empty", q_b.size(), 0);

        // Unknown code: err pulse, nothing sent, ready back next cycle
        base = sends_a; e0 = errs_a; d0 = dones_a;
        applyStimulus(8'h10, 8'h00, w);
        step();
        checkOutput("err_cycle", cyc, w + 2);
        checkOutput("err_pulse_a", err_a, 1);
        checkOutput("err_pulse_b", err_b, 1);
        checkOutput("err_ready_low", ready_a, 0);
        step();
        checkOutput("err_clear", err_a, 0);
        checkOutput("err_ready_back", ready_a, 1);
        repeat (5) step();
        checkOutput("err_count", errs_a - e0, 1);
        checkOutput("err_no_send", sends_a - base, 0);
        checkOutput("err_no_done", dones_a - d0, 0);

        // 0xFF with busy high 20 cycles before the second byte
        base = sends_a;
        applyStimulus(8'hFF, 8'h3C, w);
        waitSendsA(base + 1);
        busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("stall_no_send", send_a, 0);
            checkOutput("stall_data", data_a, 8'h78);
        end
        busy = 1'b0;
        s1 = cyc;
        step();
        checkOutput("stall_release_send", send_a, 1);
        checkOutput("stall_release_cyc", send_cyc_a[base + 1], s1 + 1);
        waitIdle("ff_finish");
        checkOutput("ff_qa_empty", q_a.size(), 0);
        checkOutput("ff_qb_empty", q_b.size(), 0);

        // Full longer message for variety
        applyStimulus(8'hFD, 8'h0F, w);
        waitIdle("fd_finish");
        checkOutput("fd_qa_empty", q_a.size(), 0);
        checkOutput("fd_qb_empty", q_b.size(), 0);

        // 0xFC: ignored wr at byte 3, reset at byte 6
        base = sends_a;
        applyStimulus(8'hFC, 8'h11, w);
        waitSendsA(base + 3);
        checkOutput("busy_not_ready", ready_a, 0);
        wr  = 1'b1;
        msg = 8'hFB;
        step();
        wr  = 1'b0;
        waitSendsA(base + 6);
        rst = 1'b0;
        step();
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        checkOutput("mid_rst_send", send_a, 0);
        checkOutput("mid_rst_data", data_a, 8'h00);
        checkOutput("mid_rst_done", done_a, 0);
        checkOutput("mid_rst_err", err_a, 0);
        checkOutput("mid_rst_ready", ready_a, 1);
        checkOutput("mid_rst_ready_b", ready_b, 1);
        checkOutput("mid_rst_data_b", data_b, 8'h00);
        s1 = sends_a; sb1 = sends_b; d0 = dones_a;
        repeat (30) step();
        checkOutput("no_resend_a", sends_a - s1, 0);
        checkOutput("no_resend_b", sends_b - sb1, 0);
        checkOutput("no_done_after_rst", dones_a - d0, 0);

        // Fresh request after reset
        base = sends_a; d0 = dones_a;
        applyStimulus(8'hFE, 8'h5A, w);
        nexp = q_a.size();
        waitIdle("fe_finish");
        checkOutput("fe_nsend", sends_a - base, nexp);
        checkOutput("fe_first_send", send_cyc_a[base], w + 3);
        checkOutput("fe_ndone", dones_a - d0, 1);
        checkOutput("fe_qa_empty", q_a.size(), 0);
        checkOutput("fe_qb_empty", q_b.size(), 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
